// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC owner and instruction fetch controller with redirect kill and 1-entry skid.
// Optional feature macro: MISALIGN_TRAP_EN (ignore misaligned jump targets and pulse misalign).
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jmp_en,
   input  logic [31:0] jmp_to,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        misalign
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_KILL} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_if_valid;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_inst;
   logic        r_skid_full;
   logic [31:0] r_skid_pc;
   logic [31:0] r_skid_inst;

   logic        w_jmp;
   logic [31:0] w_target;
   logic        w_gnt;

`ifdef MISALIGN_TRAP_EN
   logic w_misalign;
   logic r_misalign;

   assign w_misalign = jmp_en && (jmp_to[1:0] != 2'b00);
   assign w_jmp      = jmp_en && !w_misalign;
   assign w_target   = jmp_to;
   assign misalign   = r_misalign;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_misalign <= 1'b0;
      else     r_misalign <= w_misalign;
   end
`else
   assign w_jmp    = jmp_en;
   assign w_target = jmp_to & ~32'h3;
   assign misalign = 1'b0;
`endif

   // Requests are only offered when decode can take the result somewhere.
   assign imem_req  = (r_state == S_REQ) && !stall && !r_skid_full;
   assign imem_addr = r_pc;
   assign w_gnt     = imem_req && imem_gnt;

   assign if_valid = r_if_valid;
   assign if_pc    = r_if_pc;
   assign if_inst  = r_if_inst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_if_valid  <= 1'b0;
         r_if_pc     <= 32'h0;
         r_if_inst   <= NOP_INST;
         r_skid_full <= 1'b0;
         r_skid_pc   <= 32'h0;
         r_skid_inst <= NOP_INST;
      end else begin
         r_if_valid <= 1'b0;
         if (w_jmp) begin
            // Redirect wins: flush skid; a granted but unreturned fetch must be killed.
            r_pc        <= w_target;
            r_skid_full <= 1'b0;
            case (r_state)
               S_IDLE:  r_state <= S_REQ;
               S_REQ:   r_state <= w_gnt ? S_KILL : S_REQ;
               S_WAIT:  r_state <= imem_rvalid ? S_REQ : S_KILL;
               default: r_state <= imem_rvalid ? S_REQ : S_KILL;
            endcase
         end else begin
            if (r_skid_full && !stall) begin
               r_if_valid  <= 1'b1;
               r_if_pc     <= r_skid_pc;
               r_if_inst   <= r_skid_inst;
               r_skid_full <= 1'b0;
            end
            case (r_state)
               S_IDLE: r_state <= S_REQ;
               S_REQ: begin
                  if (w_gnt) r_state <= S_WAIT;
               end
               S_WAIT: begin
                  if (imem_rvalid) begin
                     if (stall) begin
                        r_skid_full <= 1'b1;
                        r_skid_pc   <= r_pc;
                        r_skid_inst <= imem_rdata;
                     end else begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_pc;
                        r_if_inst  <= imem_rdata;
                     end
                     r_pc    <= r_pc + 32'd4;
                     r_state <= S_REQ;
                  end
               end
               default: begin
                  if (imem_rvalid) r_state <= S_REQ;
               end
            endcase
         end
      end
   end

endmodule
